uart_receiver: RTL

//  Serial-to-parallel UART receiver; the other end of the board's UART transmit path.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rx_sample_tick.sv | 35 +++
 rtl/uart_receiver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART receive and transmit paths: the one-hot FSM
//   state encoding and the default frame geometry.
//   No ports; imported with "import uart_pkg::*;".
package uart_pkg;

  // Default frame geometry: 8 data bits, 16 sample ticks per bit period.
  localparam int unsigned default_word_size  = 8;
  localparam int unsigned default_oversample = 16;

  // One-hot encoding, one flop per state.
  typedef enum logic [3:0] {
    st_idle      = 4'b0001,
    st_starting  = 4'b0010,
    st_receiving = 4'b0100,
    st_stop      = 4'b1000
  } uart_state_t;

endpackage

// File: rtl/rx_sample_tick.sv
// rx_sample_tick
//   Free-running divider that produces the oversampling tick for the receiver.
//   The count only ever returns to 0 by wrapping or by reset, so the tick phase
//   is fixed from the moment reset is released.
// Ports
//   Clock   in   system clock, posedge
//   reset_  in   synchronous, active-low reset
//   tick    out  one-cycle pulse every tick_div Clock cycles
module rx_sample_tick #(
  parameter int unsigned tick_div = 326
) (
  input  logic Clock,
  input  logic reset_,
  output logic tick
);

  localparam int unsigned cnt_w = (tick_div > 2) ? $clog2(tick_div) : 1;
  localparam logic [cnt_w-1:0] last_count = cnt_w'(tick_div - 1);

  logic [cnt_w-1:0] count;

  // Wrap at tick_div-1 rather than at a power of two, so any divider works.
  always_ff @(posedge Clock) begin
    if (!reset_) begin
      count <= '0;
    end else if (count == last_count) begin
      count <= '0;
    end else begin
      count <= count + cnt_w'(1);
    end
  end

  assign tick = (count == last_count);

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   16x-oversampled UART receiver: 1 start bit (0), word_size data bits LSB
//   first, 1 stop bit (1). Delivers each good word in RCV_datareg with a ready
//   flag and reports framing and overrun errors.
// Ports
//   Clock        in   system clock, posedge
//   reset_       in   synchronous, active-low reset
//   Serial_in    in   asynchronous serial line, idles high
//   read_ack     in   one-cycle pulse: host has consumed RCV_datareg
//   RCV_datareg  out  last good received word
//   data_ready   out  RCV_datareg holds an unread word
//   error_framing out stop bit sampled as 0
//   error_overrun out frame completed while data_ready was still set
//   busy         out  FSM is not idle
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned word_size  = default_word_size,
  parameter int unsigned oversample = default_oversample,
  parameter int unsigned tick_div   = 326
) (
  input  logic                 Clock,
  input  logic                 reset_,
  input  logic                 Serial_in,
  input  logic                 read_ack,
  output logic [word_size-1:0] RCV_datareg,
  output logic                 data_ready,
  output logic                 error_framing,
  output logic                 error_overrun,
  output logic                 busy
);

  localparam int unsigned sc_w = $clog2(oversample);
  localparam int unsigned bc_w = $clog2(word_size + 1);
  localparam logic [sc_w-1:0] mid_start  = sc_w'(oversample / 2 - 1);
  localparam logic [sc_w-1:0] mid_bit    = sc_w'(oversample - 1);
  localparam logic [bc_w-1:0] last_bit   = bc_w'(word_size - 1);

  logic                 tick;
  logic                 sync1;
  logic                 sync2;
  uart_state_t          state;
  logic [sc_w-1:0]      sample_cnt;
  logic [bc_w-1:0]      bit_cnt;
  logic [word_size-1:0] shiftreg;

  rx_sample_tick #(.tick_div(tick_div)) u_tick (
    .Clock  (Clock),
    .reset_ (reset_),
    .tick   (tick)
  );

  // Two-flop synchroniser; reset to the idle (high) line level so no false
  // start bit appears after reset.
  always_ff @(posedge Clock) begin
    if (!reset_) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= Serial_in;
      sync2 <= sync1;
    end
  end

  // Receive FSM with its datapath and host-side flags. A read_ack clears the
  // flags first; a frame completing in the same cycle is assigned later in the
  // block and therefore wins. Because oversample is a power of two, sample_cnt
  // wraps to 0 on its own at the end of every bit period.
  always_ff @(posedge Clock) begin
    if (!reset_) begin
      state         <= st_idle;
      sample_cnt    <= '0;
      bit_cnt       <= '0;
      shiftreg      <= '0;
      RCV_datareg   <= '0;
      data_ready    <= 1'b0;
      error_framing <= 1'b0;
      error_overrun <= 1'b0;
    end else begin
      if (read_ack) begin
        data_ready    <= 1'b0;
        error_framing <= 1'b0;
        error_overrun <= 1'b0;
      end
      if (tick) begin
        case (state)
          st_idle: begin
            if (!sync2) begin
              state      <= st_starting;
              sample_cnt <= '0;
            end
          end
          st_starting: begin
            if (sample_cnt == mid_start) begin
              if (!sync2) begin
                state      <= st_receiving;
                sample_cnt <= '0;
                bit_cnt    <= '0;
              end else begin
                state <= st_idle;
              end
            end else begin
              sample_cnt <= sample_cnt + sc_w'(1);
            end
          end
          st_receiving: begin
            sample_cnt <= sample_cnt + sc_w'(1);
            if (sample_cnt == mid_bit) begin
              shiftreg <= {sync2, shiftreg[word_size-1:1]};
              bit_cnt  <= bit_cnt + bc_w'(1);
              if (bit_cnt == last_bit) begin
                state <= st_stop;
              end
            end
          end
          st_stop: begin
            sample_cnt <= sample_cnt + sc_w'(1);
            if (sample_cnt == mid_bit) begin
              state <= st_idle;
              if (!sync2) begin
                error_framing <= 1'b1;
              end else if (!data_ready || read_ack) begin
                RCV_datareg <= shiftreg;
                data_ready  <= 1'b1;
              end else begin
                error_overrun <= 1'b1;
              end
            end
          end
          default: state <= st_idle;
        endcase
      end
    end
  end

  assign busy = (state != st_idle);

endmodule
